regfile_write_buffer: RTL and testbench

//   Posted-write FIFO feeding the register file write port (write_enable, inp_write_address0, inp_write_data).

---
 rtl/regfile_write_buffer.sv | 117 +++++++++++
 tb/tb_regfile_write_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_buffer.sv
// Posted-write buffer in front of the register file write port.
// Producers push {address, data}; entries drain in order, one per cycle,
// unless the write port is borrowed (inp_stall). The two read results are
// corrected for writes still sitting in the buffer.
module regfile_write_buffer #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inp_valid,
    output logic          out_ready,
    input  logic [AW-1:0] inp_write_address,
    input  logic [W-1:0]  inp_write_data,
    input  logic          inp_stall,
    output logic          out_write_enable,
    output logic [AW-1:0] out_write_address,
    output logic [W-1:0]  out_write_data,
    input  logic [AW-1:0] inp_read_address0,
    input  logic [AW-1:0] inp_read_address1,
    input  logic [W-1:0]  inp_rf_read_data0,
    input  logic [W-1:0]  inp_rf_read_data1,
    output logic [W-1:0]  out_read_data0,
    output logic [W-1:0]  out_read_data1,
    output logic [CW-1:0] out_count,
    output logic          out_empty,
    output logic          out_full
);

    // Entry storage is deliberately not reset; occupancy alone decides validity.
    logic [AW-1:0] addr_q [DEPTH];
    logic [W-1:0]  data_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic push;
    logic pop;

    // Status and handshake derived from occupancy only.
    always_comb begin
        out_empty        = (count_q == '0);
        out_full         = (count_q == CW'(DEPTH));
        out_ready        = !out_full;
        out_count        = count_q;
        out_write_enable = !out_empty && !inp_stall;
        out_write_address = addr_q[rd_ptr_q];
        out_write_data    = data_q[rd_ptr_q];
        push             = inp_valid && out_ready;
        pop              = out_write_enable;
    end

    // Next-state for pointers and occupancy; pointers wrap modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards all pending writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Capture the pushed write at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= inp_write_address;
            data_q[wr_ptr_q] <= inp_write_data;
        end
    end

    // Forwarding: walk from head (oldest) to tail (youngest) so the last
    // match wins. The head being drained this cycle is still a candidate;
    // a write pushed this cycle is not yet stored and so is not seen.
    always_comb begin
        logic [PW-1:0] idx;
        idx            = '0;
        out_read_data0 = inp_rf_read_data0;
        out_read_data1 = inp_rf_read_data1;
        for (int j = 0; j < DEPTH; j++) begin
            idx = rd_ptr_q + PW'(j);
            if (CW'(j) < count_q) begin
                if (addr_q[idx] == inp_read_address0) begin
                    out_read_data0 = data_q[idx];
                end
                if (addr_q[idx] == inp_read_address1) begin
                    out_read_data1 = data_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Bench for regfile_write_buffer: queue-based model plus directed scenarios.
module tb_regfile_write_buffer;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          inp_valid;
    logic          out_ready;
    logic [AW-1:0] inp_write_address;
    logic [W-1:0]  inp_write_data;
    logic          inp_stall;
    logic          out_write_enable;
    logic [AW-1:0] out_write_address;
    logic [W-1:0]  out_write_data;
    logic [AW-1:0] inp_read_address0;
    logic [AW-1:0] inp_read_address1;
    logic [W-1:0]  inp_rf_read_data0;
    logic [W-1:0]  inp_rf_read_data1;
    logic [W-1:0]  out_read_data0;
    logic [W-1:0]  out_read_data1;
    logic [CW-1:0] out_count;
    logic          out_empty;
    logic          out_full;

    regfile_write_buffer #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk               (clk),
        .reset             (reset),
        .inp_valid         (inp_valid),
        .out_ready         (out_ready),
        .inp_write_address (inp_write_address),
        .inp_write_data    (inp_write_data),
        .inp_stall         (inp_stall),
        .out_write_enable  (out_write_enable),
        .out_write_address (out_write_address),
        .out_write_data    (out_write_data),
        .inp_read_address0 (inp_read_address0),
        .inp_read_address1 (inp_read_address1),
        .inp_rf_read_data0 (inp_rf_read_data0),
        .inp_rf_read_data1 (inp_rf_read_data1),
        .out_read_data0    (out_read_data0),
        .out_read_data1    (out_read_data1),
        .out_count         (out_count),
        .out_empty         (out_empty),
        .out_full          (out_full)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    // Model: pending writes as a queue of {addr,data}, oldest at front.
    typedef struct packed { logic [AW-1:0] a; logic [W-1:0] d; } entry_t;
    entry_t mq[$];

    function automatic logic [W-1:0] model_fwd(input logic [AW-1:0] ra, input logic [W-1:0] rf);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].a == ra) return mq[i].d;
        return rf;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
        end else begin
            automatic bit do_pop  = (mq.size() > 0) && !inp_stall;
            automatic bit do_push = inp_valid && (mq.size() < DEPTH);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({inp_write_address, inp_write_data});
        end
    end

    // Compare process: every falling edge once the bench has started.
    bit checking = 1'b0;
    always @(negedge clk) begin
        if (checking) begin
            automatic bit exp_we = (mq.size() > 0) && !inp_stall;
            chk("count", int'(out_count), mq.size());
            chk("empty", int'(out_empty), int'(mq.size() == 0));
            chk("full",  int'(out_full),  int'(mq.size() == DEPTH));
            chk("ready", int'(out_ready), int'(mq.size() < DEPTH));
            chk("we",    int'(out_write_enable), int'(exp_we));
            if (exp_we) begin
                chk("waddr", int'(out_write_address), int'(mq[0].a));
                chk("wdata", int'(out_write_data),    int'(mq[0].d));
            end
            chk("rd0", int'(out_read_data0), int'(model_fwd(inp_read_address0, inp_rf_read_data0)));
            chk("rd1", int'(out_read_data1), int'(model_fwd(inp_read_address1, inp_rf_read_data1)));
        end
    end

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [W-1:0] d, input logic s);
        inp_valid = v; inp_write_address = a; inp_write_data = d; inp_stall = s;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        inp_read_address0 = 4'd15; inp_read_address1 = 4'd14;
        inp_rf_read_data0 = 16'hC0DE; inp_rf_read_data1 = 16'hBEEF;
        tick(); tick();
        reset = 1'b0;
        checking = 1'b1;
        @(negedge clk);
        chk("rst_empty", int'(out_empty), 1);
        chk("rst_ready", int'(out_ready), 1);
        chk("rst_count", int'(out_count), 0);
        tick();

        // Test 1: reset mid-cycle with 3 entries pending
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, AW'(8 + i), W'(16'h0500 + i), 1'b1);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
        #2;
        chk("t1_pre_count", int'(out_count), 3);
        reset = 1'b1;
        #1;
        chk("t1_count", int'(out_count), 0);
        chk("t1_empty", int'(out_empty), 1);
        chk("t1_ready", int'(out_ready), 1);
        chk("t1_we",    int'(out_write_enable), 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1_no_write", int'(out_write_enable), 0);
            tick();
        end

        // Test 2: single write, one cycle of latency
        drive(1'b1, 4'd5, 16'h1234, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        chk("t2_we",   int'(out_write_enable), 1);
        chk("t2_addr", int'(out_write_address), 5);
        chk("t2_data", int'(out_write_data), 16'h1234);
        tick();
        @(negedge clk);
        chk("t2_empty", int'(out_empty), 1);
        tick();

        // Test 3: fill under stall, reject 5th push, drain in order
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, AW'(i), W'(i), 1'b1);
            tick();
        end
        drive(1'b1, 4'd6, 16'd9, 1'b1);
        @(negedge clk);
        chk("t3_count", int'(out_count), 4);
        chk("t3_full",  int'(out_full), 1);
        chk("t3_ready", int'(out_ready), 0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        #1;
        chk("t3_count_after5", int'(out_count), 4);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("t3_drain_addr", int'(out_write_address), i);
            chk("t3_drain_data", int'(out_write_data), i);
            tick();
        end
        @(negedge clk);
        chk("t3_empty", int'(out_empty), 1);
        tick();

        // Test 4: youngest of two pending writes wins
        drive(1'b1, 4'd3, 16'hAAAA, 1'b1); tick();
        drive(1'b1, 4'd3, 16'hBBBB, 1'b1); tick();
        drive(1'b0, '0, '0, 1'b1);
        inp_read_address0 = 4'd3; inp_rf_read_data0 = 16'h0000;
        inp_read_address1 = 4'd7; inp_rf_read_data1 = 16'h5A5A;
        @(negedge clk);
        chk("t4_rd0", int'(out_read_data0), 16'hBBBB);
        chk("t4_rd1", int'(out_read_data1), 16'h5A5A);
        tick();
        inp_stall = 1'b0;
        @(negedge clk);
        chk("t4_first_drain", int'(out_write_data), 16'hAAAA);
        chk("t4_rd0_drain",   int'(out_read_data0), 16'hBBBB);
        tick(); tick();

        // Test 5: same-cycle push is not forwarded
        inp_read_address0 = 4'd2; inp_rf_read_data0 = 16'h0011;
        drive(1'b1, 4'd2, 16'h00FF, 1'b0);
        @(negedge clk);
        chk("t5_rd0_now", int'(out_read_data0), 16'h0011);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        chk("t5_rd0_next", int'(out_read_data0), 16'h00FF);
        tick();

        // Test 6: streaming with wrap; address 0 forwards like any other
        inp_read_address0 = 4'd0; inp_rf_read_data0 = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, AW'(i), W'(16'h0100 + i), 1'b0);
            tick();
            @(negedge clk);
            chk("t6_count", int'(out_count), 1);
            chk("t6_data",  int'(out_write_data), 16'h0100 + i);
            if (i == 0) chk("t6_fwd_r0", int'(out_read_data0), 16'h0100);
        end
        drive(1'b0, '0, '0, 1'b0);
        tick(); tick();
        @(negedge clk);
        chk("t6_empty", int'(out_empty), 1);

        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
